// File: rtl/iq_unpack_pkg.sv
`default_nettype none
// ==== iq_unpack_pkg : shared widths, FSM state type and sample quantiser -- rev 1.0 ====
package iq_unpack_pkg;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_BYTE_SIZE = 8;
  localparam int DEF_BITS      = 10;
  localparam int QUANT_MAX_W   = 64;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_WRITE   = 1'b1
  } state_t;

  // Sign-extend a WIDTH-bit two's-complement value to QUANT_MAX_W bits, then shift left.
  function automatic logic [QUANT_MAX_W-1:0] quantize(input logic [QUANT_MAX_W-1:0] raw,
                                                      input int width,
                                                      input int shift);
    logic [QUANT_MAX_W-1:0] ext;
    logic [5:0]             msb;
    msb = 6'(width - 1);
    ext = raw;
    for (int i = 0; i < QUANT_MAX_W; i++) begin
      if (i >= width) ext[i] = raw[msb];
    end
    return ext << shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_unpack_if.sv
`default_nettype none
// ==== iq_unpack_if : byte-FIFO input, I/Q-FIFO output and control bundle -- rev 1.0 ====
interface iq_unpack_if
  import iq_unpack_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int BYTE_SIZE    = DEF_BYTE_SIZE,
  parameter int NUM_CHANNELS = 1
) ();

  logic                               in_empty;
  logic                               in_rd_en;
  logic [BYTE_SIZE-1:0]               data_in;
  logic                               out_full;
  logic                               out_wr_en;
  logic [NUM_CHANNELS*DATA_SIZE-1:0]  i_out;
  logic [NUM_CHANNELS*DATA_SIZE-1:0]  q_out;
  logic                               byte_swap;
  logic                               sync;
  logic [31:0]                        frame_count;

  modport slave (
    input  in_empty, data_in, out_full, byte_swap, sync,
    output in_rd_en, out_wr_en, i_out, q_out, frame_count
  );

  modport master (
    output in_empty, data_in, out_full, byte_swap, sync,
    input  in_rd_en, out_wr_en, i_out, q_out, frame_count
  );

endinterface
`default_nettype wire

// File: rtl/iq_sample_assemble.sv
`default_nettype none
// ==== iq_sample_assemble : orders one component's bytes and quantises the signed value -- rev 1.0 ====
module iq_sample_assemble
  import iq_unpack_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int BYTE_SIZE    = DEF_BYTE_SIZE,
  parameter int SAMPLE_BYTES = 2,
  parameter int BITS         = DEF_BITS
) (
  input  logic [SAMPLE_BYTES*BYTE_SIZE-1:0] component_bytes,
  input  logic                              byte_swap,
  output logic [DATA_SIZE-1:0]              sample
);

  localparam int RAW_W = SAMPLE_BYTES * BYTE_SIZE;

  logic [RAW_W-1:0] raw;

  // component_bytes holds arrival order (first byte lowest); swap makes the first byte the MSB.
  always_comb begin
    raw = '0;
    for (int k = 0; k < SAMPLE_BYTES; k++) begin
      if (byte_swap)
        raw[(SAMPLE_BYTES-1-k)*BYTE_SIZE +: BYTE_SIZE] = component_bytes[k*BYTE_SIZE +: BYTE_SIZE];
      else
        raw[k*BYTE_SIZE +: BYTE_SIZE] = component_bytes[k*BYTE_SIZE +: BYTE_SIZE];
    end
    sample = DATA_SIZE'(quantize(QUANT_MAX_W'(raw), RAW_W, BITS));
  end

endmodule
`default_nettype wire

// File: rtl/iq_unpack.sv
`default_nettype none
// ==== iq_unpack : I/Q byte-stream unpacker (collect/write FSM, frame register, frame counter) -- rev 1.0 ====
module iq_unpack
  import iq_unpack_pkg::*;
#(
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int BYTE_SIZE    = DEF_BYTE_SIZE,
  parameter int SAMPLE_BYTES = 2,
  parameter int BITS         = DEF_BITS,
  parameter int NUM_CHANNELS = 1
) (
  input  logic        clock,
  input  logic        reset,
  iq_unpack_if.slave  bus
);

  localparam int FRAME_BYTES = NUM_CHANNELS * 2 * SAMPLE_BYTES;
  localparam int COMP_W      = SAMPLE_BYTES * BYTE_SIZE;
  localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  generate
    if (COMP_W > DATA_SIZE || NUM_CHANNELS < 1 || DATA_SIZE > QUANT_MAX_W) begin : g_param_check
      $fatal(1, "iq_unpack: SAMPLE_BYTES*BYTE_SIZE must fit DATA_SIZE and NUM_CHANNELS must be >= 1");
    end
  endgenerate

  state_t                          state;
  state_t                          state_n;
  logic [IDX_W-1:0]                idx;
  logic [FRAME_BYTES*BYTE_SIZE-1:0] frame;
  logic                            frame_swap;
  logic [31:0]                     frame_count;
  logic                            take;
  logic                            write;

  // Strobes are forced low while reset is asserted, independent of the state register.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    write   = 1'b0;
    if (!reset) begin
      case (state)
        S_COLLECT: begin
          take = !bus.in_empty && !bus.sync;
          if (take && idx == LAST_IDX) state_n = S_WRITE;
        end
        S_WRITE: begin
          write = !bus.out_full;
          if (write) state_n = S_COLLECT;
        end
        default: state_n = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_COLLECT;
      idx         <= '0;
      frame       <= '0;
      frame_swap  <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_COLLECT && bus.sync) begin
        idx <= '0;
      end else if (take) begin
        frame[idx*BYTE_SIZE +: BYTE_SIZE] <= bus.data_in;
        if (idx == LAST_IDX) begin
          idx        <= '0;
          frame_swap <= bus.byte_swap;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (write) frame_count <= frame_count + 32'd1;
    end
  end

  assign bus.in_rd_en    = take;
  assign bus.out_wr_en   = write;
  assign bus.frame_count = frame_count;

  // Frame byte order is ch0 I, ch0 Q, ch1 I, ch1 Q, ...
  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      iq_sample_assemble #(
        .DATA_SIZE   (DATA_SIZE),
        .BYTE_SIZE   (BYTE_SIZE),
        .SAMPLE_BYTES(SAMPLE_BYTES),
        .BITS        (BITS)
      ) u_i (
        .component_bytes(frame[(2*c)*COMP_W +: COMP_W]),
        .byte_swap      (frame_swap),
        .sample         (bus.i_out[c*DATA_SIZE +: DATA_SIZE])
      );

      iq_sample_assemble #(
        .DATA_SIZE   (DATA_SIZE),
        .BYTE_SIZE   (BYTE_SIZE),
        .SAMPLE_BYTES(SAMPLE_BYTES),
        .BITS        (BITS)
      ) u_q (
        .component_bytes(frame[(2*c+1)*COMP_W +: COMP_W]),
        .byte_swap      (frame_swap),
        .sample         (bus.q_out[c*DATA_SIZE +: DATA_SIZE])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_iq_unpack.sv
`default_nettype none
// ==== tb_iq_unpack : scoreboard bench for iq_unpack (1- and 2-channel instances) -- rev 1.0 ====
module tb_iq_unpack;

  typedef struct {
    logic [63:0] i;
    logic [63:0] q;
    logic [31:0] fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  iq_unpack_if #(.NUM_CHANNELS(1)) bus0 ();
  iq_unpack_if #(.NUM_CHANNELS(2)) bus1 ();

  iq_unpack #(.NUM_CHANNELS(1)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  iq_unpack #(.NUM_CHANNELS(2)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [7:0]  fifo0[$];
  logic [7:0]  fifo1[$];
  logic [31:0] fc0 = 0;
  logic [31:0] fc1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive();
    bus0.in_empty = (fifo0.size() == 0);
    bus0.data_in  = (fifo0.size() != 0) ? fifo0[0] : 8'h00;
    bus1.in_empty = (fifo1.size() == 0);
    bus1.data_in  = (fifo1.size() != 0) ? fifo1[0] : 8'h00;
  endtask

  // One clock: pop whatever the DUTs consumed at the edge, then return 2 time units after it.
  task automatic tick();
    logic p0, p1;
    @(negedge clock);
    p0 = bus0.in_rd_en;
    p1 = bus1.in_rd_en;
    @(posedge clock);
    #1;
    if (p0 && fifo0.size() != 0) void'(fifo0.pop_front());
    if (p1 && fifo1.size() != 0) void'(fifo1.pop_front());
    drive();
    #1;
  endtask

  task automatic push0(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) fifo0.push_back(w[k*8 +: 8]);
    drive();
  endtask

  task automatic push1(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) fifo1.push_back(w[k*8 +: 8]);
    drive();
  endtask

  task automatic expect0(input logic [31:0] i, input logic [31:0] q);
    sb0.push_back('{i: {32'h0, i}, q: {32'h0, q}, fc: fc0});
    fc0++;
  endtask

  task automatic expect1(input logic [63:0] i, input logic [63:0] q);
    sb1.push_back('{i: i, q: q, fc: fc1});
    fc1++;
  endtask

  task automatic wait_done(input string name);
    bool_loop: for (int c = 0; c < 40; c++) begin
      if (fifo0.size() == 0 && fifo1.size() == 0 && sb0.size() == 0 && sb1.size() == 0)
        return;
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, fifo0=%0d sb0=%0d fifo1=%0d sb1=%0d left, expected all 0",
             name, fifo0.size(), sb0.size(), fifo1.size(), sb1.size());
  endtask

  task automatic wait_fifo0(input int level, input string name);
    for (int c = 0; c < 20; c++) begin
      if (fifo0.size() == level) return;
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: fifo0 level %0d, expected %0d", name, fifo0.size(), level);
  endtask

  // Scoreboard monitors: one per instance, comparing every presented write.
  always @(negedge clock) begin : mon0
    exp_t e;
    if (bus0.out_wr_en === 1'b1) begin
      if (sb0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL write0: unexpected write i=%h q=%h, expected none", bus0.i_out, bus0.q_out);
      end else begin
        e = sb0.pop_front();
        chk("i_out0", {32'h0, bus0.i_out}, e.i);
        chk("q_out0", {32'h0, bus0.q_out}, e.q);
        chk("frame_count0", {32'h0, bus0.frame_count}, {32'h0, e.fc});
      end
    end
  end

  always @(negedge clock) begin : mon1
    exp_t e;
    if (bus1.out_wr_en === 1'b1) begin
      if (sb1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL write1: unexpected write i=%h q=%h, expected none", bus1.i_out, bus1.q_out);
      end else begin
        e = sb1.pop_front();
        chk("i_out1", bus1.i_out, e.i);
        chk("q_out1", bus1.q_out, e.q);
        chk("frame_count1", {32'h0, bus1.frame_count}, {32'h0, e.fc});
      end
    end
  end

  initial begin
    bus0.out_full = 1'b0; bus0.byte_swap = 1'b0; bus0.sync = 1'b0;
    bus1.out_full = 1'b0; bus1.byte_swap = 1'b0; bus1.sync = 1'b0;
    drive();
    #2;
    chk("reset_rd_en", {63'h0, bus0.in_rd_en}, 64'h0);
    chk("reset_wr_en", {63'h0, bus0.out_wr_en}, 64'h0);
    chk("reset_frame_count", {32'h0, bus0.frame_count}, 64'h0);
    tick();
    tick();
    reset = 1'b0;

    // Little-endian single channel
    expect0(32'h0048D000, 32'hFEAF3400);
    push0(32'h3412CDAB);
    wait_done("le_frame");
    chk("frame_count_after_1", {32'h0, bus0.frame_count}, 64'd1);

    // Big-endian with swapped byte order gives identical samples
    bus0.byte_swap = 1'b1;
    expect0(32'h0048D000, 32'hFEAF3400);
    push0(32'h1234ABCD);
    wait_done("be_frame");
    bus0.byte_swap = 1'b0;
    chk("frame_count_after_2", {32'h0, bus0.frame_count}, 64'd2);

    // Two channels: ch1 in the upper word
    expect1({32'h00000C00, 32'h00000400}, {32'h00001000, 32'h00000800});
    push1(32'h01000200);
    push1(32'h03000400);
    wait_done("two_channel");

    // Downstream stall with the next frame already waiting in the FIFO
    bus0.out_full = 1'b1;
    expect0(32'h0048D000, 32'hFEAF3400);
    expect0(32'h00D04800, 32'hFF36AC00);
    push0(32'h3412CDAB);
    push0(32'h1234ABCD);
    wait_fifo0(4, "stall_fill");
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_wr_en", {63'h0, bus0.out_wr_en}, 64'h0);
      chk("stall_rd_en", {63'h0, bus0.in_rd_en}, 64'h0);
      chk("stall_i_out", {32'h0, bus0.i_out}, 64'h0048D000);
      chk("stall_q_out", {32'h0, bus0.q_out}, 64'hFEAF3400);
    end
    bus0.out_full = 1'b0;
    wait_done("stall_release");

    // Sync after a partial frame discards the stale bytes
    fifo0.push_back(8'hFF);
    fifo0.push_back(8'hFF);
    fifo0.push_back(8'hFF);
    drive();
    wait_fifo0(0, "partial_fill");
    tick();
    bus0.sync = 1'b1;
    push0(32'h3412CDAB);
    #1;
    chk("sync_in_empty", {63'h0, bus0.in_empty}, 64'h0);
    chk("sync_rd_en", {63'h0, bus0.in_rd_en}, 64'h0);
    tick();
    bus0.sync = 1'b0;
    expect0(32'h0048D000, 32'hFEAF3400);
    wait_done("sync_frame");

    // Reset during a stalled write: frame dropped, counter cleared
    bus0.out_full = 1'b1;
    push0(32'h3412CDAB);
    wait_fifo0(0, "reset_fill");
    tick();
    tick();
    chk("prereset_wr_en", {63'h0, bus0.out_wr_en}, 64'h0);
    reset = 1'b1;
    #1;
    chk("inreset_frame_count", {32'h0, bus0.frame_count}, 64'h0);
    bus0.out_full = 1'b0;
    push0(32'h1234ABCD);
    #1;
    chk("inreset_wr_en", {63'h0, bus0.out_wr_en}, 64'h0);
    chk("inreset_rd_en", {63'h0, bus0.in_rd_en}, 64'h0);
    tick();
    chk("inreset_wr_en_2", {63'h0, bus0.out_wr_en}, 64'h0);
    chk("inreset_fifo_level", 64'(fifo0.size()), 64'd4);
    fc0 = 0;
    fc1 = 0;
    reset = 1'b0;
    expect0(32'h00D04800, 32'hFF36AC00);
    wait_done("post_reset_frame");
    chk("frame_count_post_reset", {32'h0, bus0.frame_count}, 64'd1);

    tick();
    tick();
    chk("sb0_leftover", 64'(sb0.size()), 64'd0);
    chk("sb1_leftover", 64'(sb1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/iq_unpack.md
Name: iq_unpack

Overview:
- Generalised I/Q byte-stream unpacker for the SDR front end.
- Reads raw interleaved bytes from the input byte FIFO and assembles NUM_CHANNELS complex samples per frame.
- Each sample is SAMPLE_BYTES wide. Samples are sign-extended and quantised (left shift by BITS), then written as one parallel word-set to downstream I/Q FIFOs.
- Additions over the previous single-channel, fixed-2-byte unpacker: byte-order select, frame resync, and a frame counter.

Parameters:
- DATA_SIZE, 32, output sample width.
- BYTE_SIZE, 8, input byte width.
- SAMPLE_BYTES, 2, bytes per I or Q component.
- BITS, 10, quantisation left-shift.
- NUM_CHANNELS, 1, complex channels per frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_empty  in  1  input byte FIFO empty.
- in_rd_en  out  1  pop input byte FIFO.
- data_in  in  BYTE_SIZE  head of input FIFO; valid whenever in_empty=0.
- out_full  in  1  OR of all downstream FIFO full flags.
- out_wr_en  out  1  write strobe, common to all I/Q outputs.
- i_out  out  NUM_CHANNELS*DATA_SIZE  packed I samples; channel c at bits [c*DATA_SIZE +: DATA_SIZE].
- q_out  out  NUM_CHANNELS*DATA_SIZE  packed Q samples, same layout.
- byte_swap  in  1  0 = little-endian samples, 1 = big-endian.
- sync  in  1  discard any partial frame and realign.
- frame_count  out  32  frames written since reset; wraps modulo 2^32.

Behaviour:
- Frame size F = NUM_CHANNELS*2*SAMPLE_BYTES bytes.
- Byte order within a frame: ch0 I, ch0 Q, ch1 I, ch1 Q, ... Each component's SAMPLE_BYTES bytes are consecutive.
- Input FIFO is show-ahead: asserting in_rd_en consumes data_in in the same cycle.
- FSM states and transitions:
  - S_COLLECT: in_rd_en = !in_empty && !sync. Each consumed byte is stored at byte index idx; idx increments.
    - On consuming byte F-1: capture byte_swap into the frame register, go to S_WRITE, idx <= 0.
  - S_WRITE: in_rd_en = 0; out_wr_en = !out_full.
    - On out_wr_en: increment frame_count, go to S_COLLECT.
- Sample assembly (combinational from the frame register):
  - byte_swap=0: first byte of the component is the LSB.
  - byte_swap=1: first byte of the component is the MSB.
  - The SAMPLE_BYTES*BYTE_SIZE value is signed. Sign-extend to DATA_SIZE, shift left BITS, truncate to DATA_SIZE (wrap, no saturation).
- Output timing:
  - i_out/q_out are valid and stable throughout S_WRITE, including while stalled.
  - Their contents outside S_WRITE are don't-care.
- Latency: out_wr_en asserts at earliest one cycle after the last byte is consumed.
- Throughput: max one frame per F+1 cycles.
- Boundary conditions:
  - in_empty high mid-frame: idx holds and the partial frame is retained indefinitely.
  - out_full high in S_WRITE: no write, no byte consumption; outputs held until out_full drops.
  - sync in S_COLLECT: idx <= 0 and no byte is consumed that cycle (sync beats in_rd_en).
  - sync in S_WRITE: ignored; the pending frame still writes.
- Reset (asynchronous, any state):
  - state <= S_COLLECT, idx <= 0, frame_count <= 0, frame register <= 0.
  - in_rd_en = 0 and out_wr_en = 0 while reset is high.
- Elaboration check: fatal if SAMPLE_BYTES*BYTE_SIZE > DATA_SIZE, or NUM_CHANNELS < 1.

Decomposition:
- Shared package (existing globals): DATA_SIZE, BYTE_SIZE, BITS defaults and the quantize function (sign-extend + shift).
- Sub-module iq_sample_assemble (combinational, one instance per component): byte vector + byte_swap in, quantised DATA_SIZE word out.
- The FSM, idx counter, frame register and frame_count stay in iq_unpack.

Test Plan:
- Defaults, bytes 34 12 CD AB, swap=0 -> single out_wr_en; i_out=0x0048D000, q_out=0xFEAF3400; frame_count=1.
- Same config, bytes 12 34 AB CD, swap=1 -> identical outputs to the previous scenario.
- NUM_CHANNELS=2, bytes 01 00 02 00 03 00 04 00 -> i_out ch0=0x400, ch1=0xC00; q_out ch0=0x800, ch1=0x1000; one write.
- out_full high for 5 cycles once a frame is complete -> out_wr_en=0 and in_rd_en=0 for those 5 cycles, outputs stable; exactly one write the cycle out_full drops.
- 3 bytes FF FF FF, then sync for 1 cycle (FIFO non-empty), then 34 12 CD AB -> in_rd_en low during the sync cycle; single frame as in the first scenario; the 3 stale bytes are never output.
- Reset asserted in S_WRITE during an out_full stall -> no write; frame_count=0; after release, the next 4 bytes produce a correct frame.
